// File: rtl/core_pkg.sv
// Shared encodings for the core's hazard/sequencing logic.
package core_pkg;

  // EX-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Hazard controller sequencing states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  // Writeback source control; a load is the instruction whose result comes from memory
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC  = 2'b10
  } wb_ctr_e;

  function automatic logic wb_is_load(wb_ctr_e ctr);
    return ctr == WB_MEM;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding compare for one EX source register; MEM wins over WB, x0 never forwards.
module fwd_unit
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_reg_we_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_reg_we_i,
  output logic [1:0]            sel_o
);

  // Pick the youngest in-flight producer of ex_rs_i
  always_comb begin
    sel_o = FWD_RF;
    if (mem_reg_we_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_reg_we_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles, redirect flushes,
// data-memory wait stalls, EX operand forwarding and a stall-cycle counter.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_we,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_we,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_we,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_stall,
  output logic                  idex_flush,
  output logic                  exmem_stall,
  output logic                  memwb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_wait;
  logic             lu_hit;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs_i      (ex_rs1),
    .mem_rd_i     (mem_rd),
    .mem_reg_we_i (mem_reg_we),
    .wb_rd_i      (wb_rd),
    .wb_reg_we_i  (wb_reg_we),
    .sel_o        (fwd_a_raw)
  );

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs_i      (ex_rs2),
    .mem_rd_i     (mem_rd),
    .mem_reg_we_i (mem_reg_we),
    .wb_rd_i      (wb_rd),
    .wb_reg_we_i  (wb_reg_we),
    .sel_o        (fwd_b_raw)
  );

  assign mem_wait = mem_req & ~mem_ready;

  // Load-use detect; suppressed in LU_STALL because EX then holds the bubble, not the load
  assign lu_hit = ex_is_load & ex_reg_we & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd))) &
                  (state_q != ST_LU_STALL);

  // Control decode with priority wait > redirect > load-use; reset forces NOP injection
  always_comb begin
    state_d      = ST_RUN;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;
    if (!rst) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
    end else if (mem_wait) begin
      // EX is frozen, so redirect/load-use are re-evaluated once memory completes
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
      state_d      = ST_MEM_WAIT;
    end else if (ex_redirect) begin
      // ID holds a wrong-path instruction, so its load-use hazard is moot
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_hit) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_LU_STALL;
    end
  end

  // Sequencing state and stall-cycle counter (wraps naturally)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, pc_stall};
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_reg_we, ex_is_load, ex_redirect;
  logic          mem_reg_we, mem_req, mem_ready, wb_reg_we;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic          exmem_stall, memwb_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: counter value and whether the previous cycle inserted a load-use bubble
  int m_cnt       = 0;
  bit m_after_lu  = 0;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] ref_fwd(input int rs, input int mrd, input bit mwe,
                                         input int wrd, input bit wwe);
    if (mwe && mrd != 0 && mrd == rs) return 2'b01;
    if (wwe && wrd != 0 && wrd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_we = 0; ex_is_load = 0; ex_redirect = 0;
    mem_rd = 0; mem_reg_we = 0; mem_req = 0; mem_ready = 0; wb_rd = 0; wb_reg_we = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge
  task automatic step();
    bit w, lu;
    bit e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_bub;
    logic [1:0] e_fa, e_fb;
    @(negedge clk);
    w  = mem_req && !mem_ready;
    lu = ex_is_load && ex_reg_we && ex_rd != 0 && !m_after_lu &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    {e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_bub} = '0;
    e_fa = ref_fwd(ex_rs1, mem_rd, mem_reg_we, wb_rd, wb_reg_we);
    e_fb = ref_fwd(ex_rs2, mem_rd, mem_reg_we, wb_rd, wb_reg_we);
    if (!rst_n) begin
      e_iff = 1; e_idf = 1; e_bub = 1; e_fa = 0; e_fb = 0;
    end else if (w) begin
      e_pc = 1; e_ifs = 1; e_ids = 1; e_exs = 1; e_bub = 1;
    end else if (ex_redirect) begin
      e_iff = 1; e_idf = 1;
    end else if (lu) begin
      e_pc = 1; e_ifs = 1; e_idf = 1;
    end
    chk("pc_stall", pc_stall, e_pc);
    chk("ifid_stall", ifid_stall, e_ifs);
    chk("ifid_flush", ifid_flush, e_iff);
    chk("idex_stall", idex_stall, e_ids);
    chk("idex_flush", idex_flush, e_idf);
    chk("exmem_stall", exmem_stall, e_exs);
    chk("memwb_bubble", memwb_bubble, e_bub);
    chk("fwd_a", fwd_a, e_fa);
    chk("fwd_b", fwd_b, e_fb);
    chk("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    if (rst_n) begin
      m_cnt      = (m_cnt + (e_pc ? 1 : 0)) % (1 << CW);
      m_after_lu = rst_n && !w && !ex_redirect && lu;
    end else begin
      m_cnt = 0; m_after_lu = 0;
    end
    #1;
  endtask

  task automatic set_lu();
    ex_is_load = 1; ex_reg_we = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
  endtask

  initial begin
    idle();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();

    // Load-use: one bubble, then LU_STALL without re-detection, WB forward of the load result
    set_lu();
    step();
    chk("lu_cnt", stall_cnt, 1);
    wb_rd = 5; wb_reg_we = 1; ex_rs1 = 5;
    step();
    chk("lu_fwd_a", fwd_a, 2'b10);
    idle();
    step();

    // Redirect beats load-use
    set_lu(); ex_redirect = 1;
    step();
    chk("redir_cnt", stall_cnt, 1);
    idle();
    step();

    // Memory wait with pending redirect; flush fires on completion
    mem_req = 1; mem_ready = 0; ex_redirect = 1;
    repeat (3) step();
    chk("wait_cnt", stall_cnt, 4);
    mem_ready = 1;
    @(negedge clk);
    chk("wait_done_flush", idex_flush, 1);
    chk("wait_done_stall", pc_stall, 0);
    @(posedge clk); #1;
    idle();
    step();

    // Forward priority and x0
    mem_rd = 7; wb_rd = 7; mem_reg_we = 1; wb_reg_we = 1; ex_rs1 = 7;
    step();
    chk("fwd_pri", fwd_a, 2'b01);
    mem_rd = 0; wb_rd = 0; ex_rs2 = 0;
    step();
    chk("fwd_x0", fwd_b, 2'b00);
    idle();

    // Async reset in the middle of a memory wait
    mem_req = 1; mem_ready = 0;
    step();
    #2 rst_n = 0;
    #1;
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_flush", idex_flush, 1);
    chk("arst_stall", pc_stall, 0);
    m_cnt = 0; m_after_lu = 0;
    step();
    idle();
    rst_n = 1;
    step();

    // Counter wrap: 17 stall cycles on a 4-bit counter
    mem_req = 1; mem_ready = 0;
    repeat (17) step();
    chk("wrap", stall_cnt, 1);
    idle();
    step();

    // Randomized traffic over a small register window so hazards are frequent
    repeat (500) begin
      id_rs1      = RW'($urandom_range(0, 3));
      id_rs2      = RW'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_rs1      = RW'($urandom_range(0, 3));
      ex_rs2      = RW'($urandom_range(0, 3));
      ex_rd       = RW'($urandom_range(0, 3));
      ex_reg_we   = ($urandom_range(0, 3) != 0);
      ex_is_load  = ($urandom_range(0, 1) != 0);
      ex_redirect = ($urandom_range(0, 6) == 0);
      mem_rd      = RW'($urandom_range(0, 3));
      mem_reg_we  = 1'($urandom_range(0, 1));
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = 1'($urandom_range(0, 1));
      wb_rd       = RW'($urandom_range(0, 3));
      wb_reg_we   = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
